muldiv_seq: RTL and testbench



---
 rtl/riscv_pkg.sv | 27 ++
 rtl/muldiv_prep.sv | 52 +++++
 rtl/muldiv_seq.sv | 155 +++++++++++++++
 tb/tb_muldiv_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core definitions: ALU control codes for the M extension and muldiv FSM states.
package riscv_pkg;

    localparam logic [3:0] ALU_MUL    = 4'b1001;
    localparam logic [3:0] ALU_MULH   = 4'b1010;
    localparam logic [3:0] ALU_MULHSU = 4'b1011;
    localparam logic [3:0] ALU_MULHU  = 4'b1100;
    localparam logic [3:0] ALU_DIV    = 4'b1101;
    localparam logic [3:0] ALU_REM    = 4'b1110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    // True for any of the six multiply/divide codes.
    function automatic logic is_muldiv(input logic [3:0] code);
        return (code >= ALU_MUL) && (code <= ALU_REM);
    endfunction

    // True for the two codes that run the divider.
    function automatic logic is_div(input logic [3:0] code);
        return (code == ALU_DIV) || (code == ALU_REM);
    endfunction

endpackage

// File: rtl/muldiv_prep.sv
// Sign/magnitude conversion of operands on entry, sign fix-up and word select on exit.
module muldiv_prep
    import riscv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [3:0]         entry_op,
    input  logic [WIDTH-1:0]   entry_a,
    input  logic [WIDTH-1:0]   entry_b,
    output logic               entry_neg_a_c,
    output logic               entry_neg_b_c,
    output logic [WIDTH-1:0]   entry_mag_a_c,
    output logic [WIDTH-1:0]   entry_mag_b_c,
    input  logic [3:0]         exit_op,
    input  logic               exit_neg_a,
    input  logic               exit_neg_b,
    input  logic [2*WIDTH-1:0] exit_acc,
    output logic [WIDTH-1:0]   exit_result_c
);

    logic               signed_a;
    logic               signed_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    // Operand signedness per op; negative signed operands become magnitudes.
    always_comb begin
        signed_a      = (entry_op == ALU_MUL) || (entry_op == ALU_MULH)
                      || (entry_op == ALU_MULHSU) || is_div(entry_op);
        signed_b      = (entry_op == ALU_MUL) || (entry_op == ALU_MULH) || is_div(entry_op);
        entry_neg_a_c = signed_a & entry_a[WIDTH-1];
        entry_neg_b_c = signed_b & entry_b[WIDTH-1];
        entry_mag_a_c = entry_neg_a_c ? -entry_a : entry_a;
        entry_mag_b_c = entry_neg_b_c ? -entry_b : entry_b;
    end

    // Restore signs on the magnitude result and pick the requested word.
    always_comb begin
        prod = (exit_neg_a ^ exit_neg_b) ? -exit_acc : exit_acc;
        quot = exit_acc[WIDTH-1:0];
        rem  = exit_acc[2*WIDTH-1:WIDTH];
        case (exit_op)
            ALU_MUL:                        exit_result_c = prod[WIDTH-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: exit_result_c = prod[2*WIDTH-1:WIDTH];
            ALU_DIV:                        exit_result_c = (exit_neg_a ^ exit_neg_b) ? -quot : quot;
            ALU_REM:                        exit_result_c = exit_neg_a ? -rem : rem;
            default:                        exit_result_c = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide: one shift/add or shift/subtract step per cycle.
module muldiv_seq
    import riscv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CNTW = $clog2(WIDTH) + 1;
    localparam int unsigned AW   = 2 * WIDTH;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    muldiv_state_t    state;
    logic [3:0]       op;
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [AW-1:0]    acc;
    logic [CNTW-1:0]  cnt;

    logic             entry_neg_a_c;
    logic             entry_neg_b_c;
    logic [WIDTH-1:0] entry_mag_a_c;
    logic [WIDTH-1:0] entry_mag_b_c;
    logic [WIDTH-1:0] exit_result_c;

    logic             fast_c;
    logic [WIDTH-1:0] fast_result_c;
    logic [AW-1:0]    acc_step_c;
    logic [CNTW-1:0]  cnt_next_c;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;
    logic             q_bit;

    muldiv_prep #(.WIDTH(WIDTH)) u_prep (
        .entry_op      (alucontrol),
        .entry_a       (srca),
        .entry_b       (srcb),
        .entry_neg_a_c (entry_neg_a_c),
        .entry_neg_b_c (entry_neg_b_c),
        .entry_mag_a_c (entry_mag_a_c),
        .entry_mag_b_c (entry_mag_b_c),
        .exit_op       (op),
        .exit_neg_a    (neg_a),
        .exit_neg_b    (neg_b),
        .exit_acc      (acc_step_c),
        .exit_result_c (exit_result_c)
    );

    // Requests answered without iterating: illegal code, divide by zero, signed overflow.
    always_comb begin
        fast_c        = 1'b0;
        fast_result_c = '0;
        if (!is_muldiv(alucontrol)) begin
            fast_c = 1'b1;
        end else if (is_div(alucontrol) && (srcb == '0)) begin
            fast_c        = 1'b1;
            fast_result_c = (alucontrol == ALU_DIV) ? '1 : srca;
        end else if (is_div(alucontrol) && (srca == MIN_NEG) && (&srcb)) begin
            fast_c        = 1'b1;
            fast_result_c = (alucontrol == ALU_DIV) ? MIN_NEG : '0;
        end
    end

    // One iteration: LSB-first shift-add for multiply, MSB-first restoring step for divide.
    always_comb begin
        addend     = opb[0] ? opa : '0;
        mul_sum    = {1'b0, acc[AW-1:WIDTH]} + {1'b0, addend};
        trial      = {acc[AW-1:WIDTH], opa[WIDTH-1]};
        q_bit      = (trial >= {1'b0, opb});
        diff       = trial[WIDTH-1:0] - opb;
        cnt_next_c = cnt + CNTW'(1);
        if (is_div(op)) begin
            acc_step_c = {(q_bit ? diff : trial[WIDTH-1:0]), acc[WIDTH-2:0], q_bit};
        end else begin
            acc_step_c = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // Control FSM, operand/accumulator registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            op     <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op    <= alucontrol;
                        neg_a <= entry_neg_a_c;
                        neg_b <= entry_neg_b_c;
                        opa   <= entry_mag_a_c;
                        opb   <= entry_mag_b_c;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        if (fast_c) begin
                            result <= fast_result_c;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_step_c;
                    cnt <= cnt_next_c;
                    if (is_div(op)) begin
                        opa <= {opa[WIDTH-2:0], 1'b0};
                    end else begin
                        opb <= {1'b0, opb[WIDTH-1:1]};
                    end
                    if (cnt_next_c == CNTW'(WIDTH)) begin
                        result <= exit_result_c;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq against a 64-bit arithmetic reference.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  alucontrol;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .alucontrol (alucontrol),
        .srca       (srca),
        .srcb       (srcb),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference result straight from RV32M semantics.
    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      p;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'b1001: begin p = sa * sb; return p[31:0]; end
            4'b1010: begin p = sa * sb; return p[63:32]; end
            4'b1011: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            4'b1100: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            4'b1101: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            4'b1110: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op < 4'd9 || op > 4'd14) return 1;
        if ((op == 4'd13 || op == 4'd14) &&
            (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op from an idle cycle; optionally inject an ignored start at T+inject_at.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int inject_at);
        logic [31:0] exp;
        int          lat;
        int          n;
        exp        = ref_result(op, a, b);
        lat        = ref_latency(op, a, b);
        start      = 1'b1;
        alucontrol = op;
        srca       = a;
        srcb       = b;
        @(posedge clk); #1;
        n = 1;
        start      = 1'b0;
        alucontrol = 4'($urandom);
        srca       = $urandom;
        srcb       = $urandom;
        check({tag, " busy@T+1"}, {31'b0, busy}, 32'd1);
        while (done !== 1'b1 && n < 40) begin
            if (n == inject_at) begin
                start      = 1'b1;
                alucontrol = 4'($urandom_range(9, 14));
                srca       = $urandom;
                srcb       = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(n), 32'(lat));
        check({tag, " result"}, result, exp);
        check({tag, " busy@done"}, {31'b0, busy}, 32'd1);
        @(posedge clk); #1;
        check({tag, " done low"}, {31'b0, done}, 32'd0);
        check({tag, " busy low"}, {31'b0, busy}, 32'd0);
        check({tag, " result held"}, result, exp);
    endtask

    task automatic run_reset_abort();
        int pulses;
        start      = 1'b1;
        alucontrol = 4'b1001;
        srca       = 32'd12345;
        srcb       = 32'd678;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i < 15; i++) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort busy", {31'b0, busy}, 32'd0);
        check("abort done", {31'b0, done}, 32'd0);
        check("abort result", result, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        check("abort no done", 32'(pulses), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        alucontrol = 4'd0;
        srca       = 32'd0;
        srcb       = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", result, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op("mul 7*-3", 4'b1001, 32'd7, 32'hFFFF_FFFD, 0);
        run_op("mulh min*min", 4'b1010, 32'h8000_0000, 32'h8000_0000, 0);
        run_op("mulhu ff*ff", 4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mulhsu ff*ff", 4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("div -7/2", 4'b1101, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("rem -7/2", 4'b1110, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("div 5/0", 4'b1101, 32'd5, 32'd0, 0);
        run_op("rem 5/0", 4'b1110, 32'd5, 32'd0, 0);
        run_op("div ovf", 4'b1101, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("rem ovf", 4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("illegal 1111", 4'b1111, 32'd9, 32'd3, 0);
        run_op("mul ignore start", 4'b1001, 32'h1234_5678, 32'h0000_0ABC, 10);
        run_reset_abort();
        run_op("mul after abort", 4'b1001, 32'd12345, 32'd678, 0);

        for (int k = 0; k < 40; k++) begin
            logic [3:0] rop;
            if ($urandom_range(0, 9) < 9) rop = 4'($urandom_range(9, 14));
            else                          rop = 4'($urandom_range(0, 15));
            run_op($sformatf("rand%0d op%0d", k, rop), rop, pick(), pick(),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 30)) : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
